// File: rtl/axil_pkg.sv
// Shared AXI-Lite types: response codes and the arbiter path FSM states.
package axil_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;

endpackage

// File: rtl/axil_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', with wrap.
module axil_rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last,
    output logic [PW-1:0] winner,
    output logic          any
);

    logic [PW-1:0] idx;

    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        winner = '0;
        any    = |req;
        idx    = '0;
        for (int unsigned i = N; i >= 1; i--) begin
            idx = PW'((32'(last) + i) % N);
            if (req[idx]) winner = idx;
        end
    end

endmodule

// File: rtl/axil_rr_arbiter.sv
// Round-robin AXI-Lite arbiter: N masters onto one slave, independent
// write and read paths, one transaction in flight per path.
module axil_rr_arbiter
    import axil_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]  m_awaddr,
    input  logic [NUM_MASTERS-1:0]                 m_awvalid,
    output logic [NUM_MASTERS-1:0]                 m_awready,
    input  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]  m_wdata,
    input  logic [NUM_MASTERS*AXI_DATA_WIDTH/8-1:0] m_wstrb,
    input  logic [NUM_MASTERS-1:0]                 m_wvalid,
    output logic [NUM_MASTERS-1:0]                 m_wready,
    output logic [NUM_MASTERS*2-1:0]               m_bresp,
    output logic [NUM_MASTERS-1:0]                 m_bvalid,
    input  logic [NUM_MASTERS-1:0]                 m_bready,
    input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0]  m_araddr,
    input  logic [NUM_MASTERS-1:0]                 m_arvalid,
    output logic [NUM_MASTERS-1:0]                 m_arready,
    output logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0]  m_rdata,
    output logic [NUM_MASTERS*2-1:0]               m_rresp,
    output logic [NUM_MASTERS-1:0]                 m_rvalid,
    input  logic [NUM_MASTERS-1:0]                 m_rready,
    output logic [AXI_ADDR_WIDTH-1:0]              s_awaddr,
    output logic                                   s_awvalid,
    input  logic                                   s_awready,
    output logic [AXI_DATA_WIDTH-1:0]              s_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]            s_wstrb,
    output logic                                   s_wvalid,
    input  logic                                   s_wready,
    input  logic [1:0]                             s_bresp,
    input  logic                                   s_bvalid,
    output logic                                   s_bready,
    output logic [AXI_ADDR_WIDTH-1:0]              s_araddr,
    output logic                                   s_arvalid,
    input  logic                                   s_arready,
    input  logic [AXI_DATA_WIDTH-1:0]              s_rdata,
    input  logic [1:0]                             s_rresp,
    input  logic                                   s_rvalid,
    output logic                                   s_rready
);

    localparam int unsigned PW = $clog2(NUM_MASTERS);
    localparam int unsigned SW = AXI_DATA_WIDTH / 8;

    wr_state_t     wr_state_q, wr_state_d;
    logic [PW-1:0] wr_grant_q, wr_grant_d, wr_last_q, wr_last_d, wr_winner;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d, wr_any;

    rd_state_t     rd_state_q, rd_state_d;
    logic [PW-1:0] rd_grant_q, rd_grant_d, rd_last_q, rd_last_d, rd_winner;
    logic          rd_any;

    axil_rr_pick #(.N(NUM_MASTERS), .PW(PW)) u_wr_pick (
        .req    (m_awvalid | m_wvalid),
        .last   (wr_last_q),
        .winner (wr_winner),
        .any    (wr_any)
    );

    axil_rr_pick #(.N(NUM_MASTERS), .PW(PW)) u_rd_pick (
        .req    (m_arvalid),
        .last   (rd_last_q),
        .winner (rd_winner),
        .any    (rd_any)
    );

    // State registers; pointers reset to the last lane so master 0 wins first.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_q <= WR_IDLE;
            wr_grant_q <= '0;
            wr_last_q  <= PW'(NUM_MASTERS - 1);
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            rd_state_q <= RD_IDLE;
            rd_grant_q <= '0;
            rd_last_q  <= PW'(NUM_MASTERS - 1);
        end else begin
            wr_state_q <= wr_state_d;
            wr_grant_q <= wr_grant_d;
            wr_last_q  <= wr_last_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            rd_state_q <= rd_state_d;
            rd_grant_q <= rd_grant_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Write path: arbitrate, forward AW and W independently, then route B.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_grant_d = wr_grant_q;
        wr_last_d  = wr_last_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m_awready  = '0;
        m_wready   = '0;
        m_bresp    = '0;
        m_bvalid   = '0;
        case (wr_state_q)
            WR_IDLE: begin
                if (wr_any) begin
                    wr_grant_d = wr_winner;
                    wr_last_d  = wr_winner;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = WR_ADDR;
                end
            end
            WR_ADDR: begin
                s_awaddr  = m_awaddr[wr_grant_q*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                s_awvalid = m_awvalid[wr_grant_q] & ~aw_done_q;
                s_wdata   = m_wdata[wr_grant_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                s_wstrb   = m_wstrb[wr_grant_q*SW +: SW];
                s_wvalid  = m_wvalid[wr_grant_q] & ~w_done_q;
                m_awready[wr_grant_q] = s_awready & ~aw_done_q;
                m_wready[wr_grant_q]  = s_wready & ~w_done_q;
                aw_done_d = aw_done_q | (m_awvalid[wr_grant_q] & s_awready);
                w_done_d  = w_done_q | (m_wvalid[wr_grant_q] & s_wready);
                // Include this cycle's handshakes so AW+W together cost one cycle.
                if (aw_done_d && w_done_d) wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                m_bvalid[wr_grant_q]          = s_bvalid;
                m_bresp[wr_grant_q*2 +: 2]    = s_bresp;
                s_bready                      = m_bready[wr_grant_q];
                if (s_bvalid && m_bready[wr_grant_q]) wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Read path: arbitrate, forward AR, then route R back to the granted lane.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        rd_last_d  = rd_last_q;
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m_arready  = '0;
        m_rdata    = '0;
        m_rresp    = '0;
        m_rvalid   = '0;
        case (rd_state_q)
            RD_IDLE: begin
                if (rd_any) begin
                    rd_grant_d = rd_winner;
                    rd_last_d  = rd_winner;
                    rd_state_d = RD_ADDR;
                end
            end
            RD_ADDR: begin
                s_araddr  = m_araddr[rd_grant_q*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                s_arvalid = m_arvalid[rd_grant_q];
                m_arready[rd_grant_q] = s_arready;
                if (m_arvalid[rd_grant_q] && s_arready) rd_state_d = RD_DATA;
            end
            RD_DATA: begin
                m_rvalid[rd_grant_q] = s_rvalid;
                m_rdata[rd_grant_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = s_rdata;
                m_rresp[rd_grant_q*2 +: 2] = s_rresp;
                s_rready = m_rready[rd_grant_q];
                if (s_rvalid && m_rready[rd_grant_q]) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed bench for axil_rr_arbiter with two masters and a scripted slave.
module tb_axil_rr_arbiter;
    import axil_pkg::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
    logic [3:0]  m_bresp, m_rresp;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;

    int checks = 0;
    int errors = 0;

    logic [31:0] wa   [2];
    logic [31:0] wdat [2];
    logic [3:0]  wst  [2];
    logic [31:0] ra   [2];

    typedef struct {
        logic [1:0] req;
        int         g;
        logic [1:0] resp;
        int         aw_lat;
        int         w_lat;
    } wr_vec_t;

    wr_vec_t vecs [6];

    axil_rr_arbiter #(.NUM_MASTERS(2), .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) dut (
        .aclk(aclk), .areset(areset),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 aclk = ~aclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, 64'(|{m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp,
                        m_rvalid, s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
                        s_araddr, s_arvalid, s_rready}), 64'd0);
    endtask

    task automatic set_wr(input int i);
        m_awvalid[i] = 1'b1;
        m_wvalid[i]  = 1'b1;
        m_awaddr[i*32 +: 32] = wa[i];
        m_wdata[i*32 +: 32]  = wdat[i];
        m_wstrb[i*4 +: 4]    = wst[i];
    endtask

    task automatic set_rd(input int i);
        m_arvalid[i] = 1'b1;
        m_araddr[i*32 +: 32] = ra[i];
    endtask

    // Starts at a negedge with the write path idle and lane g's valids driven.
    task automatic wr_txn(input int g, input logic [1:0] resp, input int aw_lat,
                          input int w_lat, input string tag);
        logic [1:0] oh;
        bit awd, wd;
        int cyc;
        oh = 2'b01 << g;
        #1;
        chk({tag, "_idle_valid"}, 64'({s_awvalid, s_wvalid}), 64'd0);
        @(negedge aclk);
        awd = 0; wd = 0; cyc = 0;
        while (!(awd && wd) && cyc < 20) begin
            s_awready = (cyc >= aw_lat);
            s_wready  = (cyc >= w_lat);
            #1;
            chk({tag, "_s_awvalid"}, 64'(s_awvalid), 64'(!awd));
            chk({tag, "_s_wvalid"}, 64'(s_wvalid), 64'(!wd));
            chk({tag, "_m_awready"}, 64'(m_awready), 64'((s_awready && !awd) ? oh : 2'b00));
            chk({tag, "_m_wready"}, 64'(m_wready), 64'((s_wready && !wd) ? oh : 2'b00));
            if (!awd) chk({tag, "_s_awaddr"}, 64'(s_awaddr), 64'(wa[g]));
            if (!wd) begin
                chk({tag, "_s_wdata"}, 64'(s_wdata), 64'(wdat[g]));
                chk({tag, "_s_wstrb"}, 64'(s_wstrb), 64'(wst[g]));
            end
            if (!awd && s_awready) awd = 1;
            if (!wd && s_wready) wd = 1;
            @(negedge aclk);
            if (awd) m_awvalid[g] = 1'b0;
            if (wd) m_wvalid[g] = 1'b0;
            cyc++;
        end
        s_awready = 1'b0;
        s_wready  = 1'b0;
        #1;
        chk({tag, "_resp_wait"}, 64'({s_awvalid, s_wvalid, m_bvalid}), 64'd0);
        @(negedge aclk);
        s_bvalid = 1'b1;
        s_bresp  = resp;
        m_bready = oh;
        #1;
        chk({tag, "_m_bvalid"}, 64'(m_bvalid), 64'(oh));
        chk({tag, "_m_bresp"}, 64'(m_bresp), 64'(resp) << (2 * g));
        chk({tag, "_s_bready"}, 64'(s_bready), 64'd1);
        @(negedge aclk);
        s_bvalid = 1'b0;
        s_bresp  = 2'b00;
        m_bready = 2'b00;
    endtask

    // Starts at a negedge with the read path idle and lane g's arvalid driven.
    task automatic rd_txn(input int g, input logic [31:0] data, input logic [1:0] resp,
                          input int lat, input string tag);
        logic [1:0] oh;
        bit ard;
        int cyc;
        oh = 2'b01 << g;
        #1;
        chk({tag, "_idle_arvalid"}, 64'(s_arvalid), 64'd0);
        @(negedge aclk);
        ard = 0; cyc = 0;
        while (!ard && cyc < 20) begin
            s_arready = (cyc >= lat);
            #1;
            chk({tag, "_s_arvalid"}, 64'(s_arvalid), 64'd1);
            chk({tag, "_s_araddr"}, 64'(s_araddr), 64'(ra[g]));
            chk({tag, "_m_arready"}, 64'(m_arready), 64'(s_arready ? oh : 2'b00));
            if (s_arready) ard = 1;
            @(negedge aclk);
            if (ard) m_arvalid[g] = 1'b0;
            cyc++;
        end
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = data;
        s_rresp   = resp;
        m_rready  = oh;
        #1;
        chk({tag, "_no_arvalid"}, 64'(s_arvalid), 64'd0);
        chk({tag, "_m_rvalid"}, 64'(m_rvalid), 64'(oh));
        chk({tag, "_m_rdata"}, m_rdata, 64'(data) << (32 * g));
        chk({tag, "_m_rresp"}, 64'(m_rresp), 64'(resp) << (2 * g));
        chk({tag, "_s_rready"}, 64'(s_rready), 64'd1);
        @(negedge aclk);
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_rresp  = 2'b00;
        m_rready = 2'b00;
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
    endtask

    initial begin
        // Round-robin table: requests added, expected grant, slave response, delays.
        vecs[0] = '{2'b11, 0, RESP_OKAY,   0, 0};
        vecs[1] = '{2'b11, 1, RESP_EXOKAY, 1, 0};
        vecs[2] = '{2'b11, 0, RESP_SLVERR, 0, 2};
        vecs[3] = '{2'b11, 1, RESP_DECERR, 2, 2};
        vecs[4] = '{2'b01, 0, RESP_OKAY,   0, 0};
        vecs[5] = '{2'b10, 1, RESP_OKAY,   3, 0}; // W lands 3 cycles before AW

        m_awaddr = '0; m_wdata = '0; m_wstrb = '0; m_araddr = '0;
        m_awvalid = 2'b11; m_wvalid = 2'b11; m_bready = 2'b11;
        m_arvalid = 2'b11; m_rready = 2'b11;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b1; s_bresp = 2'b11;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 32'hFFFF_FFFF; s_rresp = 2'b11;
        areset = 1'b1;

        repeat (2) @(negedge aclk);
        #1;
        chk_zero("reset_outputs");
        @(negedge aclk);
        m_awvalid = '0; m_wvalid = '0; m_bready = '0; m_arvalid = '0; m_rready = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        areset = 1'b0;

        // Single write from master 0.
        wa[0] = 32'h10; wdat[0] = 32'hA5A5_A5A5; wst[0] = 4'hF;
        wa[1] = 32'h14; wdat[1] = 32'h5A5A_5A5A; wst[1] = 4'h3;
        set_wr(0);
        wr_txn(0, RESP_OKAY, 0, 0, "t1");

        // Both masters requesting continuously, then lone requesters.
        pulse_reset();
        wa[0] = 32'h100; wdat[0] = 32'h1111_0000; wst[0] = 4'h1;
        wa[1] = 32'h200; wdat[1] = 32'h2222_0000; wst[1] = 4'hC;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 2; i++) if (vecs[k].req[i]) set_wr(i);
            wr_txn(vecs[k].g, vecs[k].resp, vecs[k].aw_lat, vecs[k].w_lat,
                   $sformatf("t2_v%0d", k));
        end

        // Concurrent read (m0) and write (m1).
        ra[0] = 32'h20; wa[1] = 32'h30; wdat[1] = 32'hCAFE_F00D; wst[1] = 4'hF;
        set_rd(0);
        set_wr(1);
        fork
            rd_txn(0, 32'h1234_5678, RESP_OKAY, 1, "t4_rd");
            wr_txn(1, RESP_OKAY, 0, 1, "t4_wr");
        join

        // Reset in WR_RESP while the slave has no response yet.
        wa[0] = 32'h40;
        set_wr(0);
        s_awready = 1'b1; s_wready = 1'b1; m_bready = 2'b01;
        @(negedge aclk);
        @(negedge aclk);
        m_awvalid = '0; m_wvalid = '0; s_awready = 1'b0; s_wready = 1'b0;
        #1;
        chk("t5_pre_s_bready", 64'(s_bready), 64'd1);
        areset = 1'b1;
        #1;
        chk_zero("t5_reset_outputs");
        @(negedge aclk);
        m_bready = '0;
        areset = 1'b0;
        set_wr(0);
        set_wr(1);
        wr_txn(0, RESP_OKAY, 0, 0, "t5_first");
        wr_txn(1, RESP_OKAY, 0, 0, "t5_second");

        // SLVERR read for m1, then m0 is favoured.
        ra[0] = 32'h50; ra[1] = 32'h60;
        set_rd(1);
        rd_txn(1, 32'hDEAD_BEEF, RESP_SLVERR, 2, "t6_err");
        set_rd(0);
        set_rd(1);
        rd_txn(0, 32'h0BAD_CAFE, RESP_OKAY, 0, "t6_m0");
        rd_txn(1, 32'h7777_8888, RESP_EXOKAY, 0, "t6_m1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
